// File: rtl/cmp_decision_rx.sv
// Comparator decision receiver: synchronises the latched comparator output, samples it
// on each falling edge of cmp_p1, and returns ones-counts per window over valid/ready.
module cmp_decision_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int WIN_LOG2    = 6,
    parameter int CNT_W       = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cmp_p1,
    input  logic             cmp_out,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun,
    output logic             busy,
    output logic             decision
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ACQ  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  cmp_s;
    logic                  p1_q;
    logic                  strb;
    logic                  rise;
    logic [CNT_W-1:0]      acc, acc_nxt;
    logic [WIN_LOG2-1:0]   dec_cnt, dec_cnt_nxt;
    logic [CNT_W-1:0]      win_sum;
    logic                  win_done;
    logic                  overrun_clr;

    function automatic logic [CNT_W-1:0] add_bit(input logic [CNT_W-1:0] a, input logic b);
        return a + {{(CNT_W-1){1'b0}}, b};
    endfunction

    // Input stage: cmp_out synchroniser and cmp_p1 edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            p1_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_out};
            p1_q   <= cmp_p1;
        end
    end

    assign cmp_s = sync_q[SYNC_STAGES-1];
    assign strb  = p1_q & ~cmp_p1;
    assign rise  = ~p1_q & cmp_p1;

    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        dec_cnt_nxt = dec_cnt;
        win_done    = 1'b0;
        overrun_clr = 1'b0;
        win_sum     = add_bit(acc, cmp_s);
        case (state)
            IDLE: begin
                acc_nxt     = '0;
                dec_cnt_nxt = '0;
                if (enable) begin
                    state_nxt   = ARM;
                    overrun_clr = 1'b1;
                end
            end
            ARM: begin
                if (!enable)
                    state_nxt = IDLE;
                else if (rise)
                    state_nxt = ACQ;
            end
            ACQ: begin
                // Dropping enable wins over a coincident strobe: the partial window is discarded.
                if (!enable) begin
                    state_nxt   = IDLE;
                    acc_nxt     = '0;
                    dec_cnt_nxt = '0;
                end else if (strb) begin
                    dec_cnt_nxt = dec_cnt + 1'b1;
                    if (dec_cnt == '1) begin
                        win_done = 1'b1;
                        acc_nxt  = '0;
                    end else begin
                        acc_nxt = win_sum;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulation stage: FSM, window counters and last decision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            dec_cnt  <= '0;
            decision <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            dec_cnt <= dec_cnt_nxt;
            if (strb)
                decision <= cmp_s;
        end
    end

    // Output stage: result hand-off to the back end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (win_done) begin
                // A completing window may only replace a result that is gone or leaving now.
                if (!result_valid || result_ready) begin
                    result       <= win_sum;
                    result_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cmp_decision_rx.sv
// Bench for cmp_decision_rx: directed scenarios plus randomized traffic, compared every
// cycle against a queue-based window model of the receiver.
`timescale 1ns/1ps
module tb_cmp_decision_rx;

    localparam int WIN_LOG2 = 6;
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int CNT_W    = WIN_LOG2 + 1;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_ACQ  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             cmp_p1;
    logic             cmp_out;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             overrun;
    logic             busy;
    logic             decision;

    int tests  = 0;
    int failed = 0;
    int cycle  = 0;

    int m_mode;
    bit m_p1q;
    bit m_valid;
    int m_res;
    bit m_ovr;
    bit m_dec;
    bit win_q[$];

    bit rand_ready = 1'b0;
    bit prev_v     = 1'b0;
    int rise_cyc[$];
    int rise_val[$];

    always #5 clk = ~clk;

    cmp_decision_rx #(
        .SYNC_STAGES(2),
        .WIN_LOG2   (WIN_LOG2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmp_p1      (cmp_p1),
        .cmp_out     (cmp_out),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .overrun     (overrun),
        .busy        (busy),
        .decision    (decision)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_p1q   = 1'b0;
        m_valid = 1'b0;
        m_res   = 0;
        m_ovr   = 1'b0;
        m_dec   = 1'b0;
        win_q.delete();
    endtask

    // One clock: update the model from the inputs present before the edge, then compare.
    task automatic tick();
        bit strb_m;
        bit rise_m;
        bit done;
        int sum;
        done = 1'b0;
        sum  = 0;
        if (rand_ready)
            result_ready = 1'($urandom_range(0, 1));
        if (reset) begin
            model_reset();
        end else begin
            strb_m = m_p1q && !cmp_p1;
            rise_m = !m_p1q && cmp_p1;
            if (strb_m)
                m_dec = cmp_out;
            case (m_mode)
                M_IDLE: if (enable) begin
                    m_mode = M_ARM;
                    m_ovr  = 1'b0;
                end
                M_ARM: begin
                    if (!enable)
                        m_mode = M_IDLE;
                    else if (rise_m)
                        m_mode = M_ACQ;
                end
                default: begin
                    if (!enable) begin
                        m_mode = M_IDLE;
                        win_q.delete();
                    end else if (strb_m) begin
                        win_q.push_back(cmp_out);
                        if (win_q.size() == WIN) begin
                            foreach (win_q[i]) sum += int'(win_q[i]);
                            win_q.delete();
                            done = 1'b1;
                        end
                    end
                end
            endcase
            if (done) begin
                if (!m_valid || result_ready) begin
                    m_res   = sum;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && result_ready) begin
                m_valid = 1'b0;
            end
            m_p1q = cmp_p1;
        end
        @(posedge clk);
        #1;
        cycle++;
        chk("result", 32'(result), m_res);
        chk("result_valid", 32'(result_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("decision", 32'(decision), 32'(m_dec));
        if (result_valid === 1'b1 && !prev_v) begin
            rise_cyc.push_back(cycle);
            rise_val.push_back(int'(result));
        end
        prev_v = (result_valid === 1'b1);
    endtask

    // One phase-1 period of 8 clocks; cmp_out is set at the rise and held through the fall.
    task automatic phase(input bit b);
        cmp_out = b;
        cmp_p1  = 1'b1;
        repeat (4) tick();
        cmp_p1 = 1'b0;
        repeat (4) tick();
    endtask

    task automatic window(input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            s += int'(b);
            phase(b);
        end
    endtask

    initial begin
        int s1;
        int s2;
        int s;
        reset        = 1'b1;
        enable       = 1'b0;
        cmp_p1       = 1'b0;
        cmp_out      = 1'b0;
        result_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("t0_result", 32'(result), 0);
        chk("t0_valid", 32'(result_valid), 0);
        chk("t0_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();

        // Constant ones: full window of 64, valid on the edge after the 64th fall
        enable = 1'b1;
        tick();
        chk("t1_armed", 32'(busy), 1);
        repeat (WIN - 1) phase(1'b1);
        cmp_out = 1'b1;
        cmp_p1  = 1'b1;
        repeat (4) tick();
        cmp_p1 = 1'b0;
        chk("t1_not_early", 32'(result_valid), 0);
        tick();
        chk("t1_valid", 32'(result_valid), 1);
        chk("t1_result", 32'(result), 64);
        repeat (3) tick();
        result_ready = 1'b1;
        tick();
        chk("t1_accept", 32'(result_valid), 0);

        // Alternating decisions with ready high: 32 per window, 512 clocks apart
        rise_cyc.delete();
        rise_val.delete();
        for (int i = 0; i < 2 * WIN; i++) phase(i % 2 == 0);
        chk("t2_windows", rise_cyc.size(), 2);
        if (rise_cyc.size() >= 2) begin
            chk("t2_res0", rise_val[0], 32);
            chk("t2_res1", rise_val[1], 32);
            chk("t2_spacing", rise_cyc[1] - rise_cyc[0], 512);
        end

        // Two windows unconsumed: first held, overrun set
        result_ready = 1'b0;
        window(WIN, s1);
        window(WIN, s2);
        chk("t3_valid", 32'(result_valid), 1);
        chk("t3_result", 32'(result), s1);
        chk("t3_overrun", 32'(overrun), 1);
        result_ready = 1'b1;
        tick();
        chk("t3_drop", 32'(result_valid), 0);
        chk("t3_kept", 32'(result), s1);
        result_ready = 1'b0;

        // Re-arm clears overrun; accept on the exact completion edge of window 2
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk("t4_ovr_clr", 32'(overrun), 0);
        window(WIN, s1);
        chk("t4_w1", 32'(result), s1);
        window(WIN - 1, s2);
        cmp_out = 1'($urandom_range(0, 1));
        s2 += int'(cmp_out);
        cmp_p1 = 1'b1;
        repeat (4) tick();
        cmp_p1       = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("t4_valid", 32'(result_valid), 1);
        chk("t4_result", 32'(result), s2);
        chk("t4_overrun", 32'(overrun), 0);
        repeat (3) tick();

        // Abort after 20 decisions: partial window yields nothing
        result_ready = 1'b1;
        tick();
        rise_cyc.delete();
        rise_val.delete();
        window(20, s);
        enable = 1'b0;
        repeat (4) tick();
        chk("t5_idle", 32'(busy), 0);
        enable = 1'b1;
        tick();
        window(WIN, s);
        repeat (2) tick();
        chk("t5_count", rise_val.size(), 1);
        if (rise_val.size() >= 1)
            chk("t5_result", rise_val[0], s);

        // Asynchronous reset mid-window with a pending result
        result_ready = 1'b0;
        window(WIN, s1);
        chk("t6_pending", 32'(result_valid), 1);
        window(10, s);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_async_result", 32'(result), 0);
        chk("t6_async_valid", 32'(result_valid), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_dec", 32'(decision), 0);
        tick();
        reset = 1'b0;
        tick();
        window(WIN - 1, s2);
        chk("t6_no_early", 32'(result_valid), 0);
        window(1, s);
        s2 += s;
        chk("t6_valid", 32'(result_valid), 1);
        chk("t6_result", 32'(result), s2);

        // Randomized traffic: random bits, random ready, occasional enable drops
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            enable = ($urandom_range(0, 39) != 0);
            phase(1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
